// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the PC fetch sequencer.
package pc_fetch_ctrl_pkg;

  localparam int          INSTR_W           = 32;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h00000013;  // addi x0,x0,0
  localparam logic [31:0] TRAP_VEC_DEFAULT  = 32'h00000100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  // Redirect targets are word aligned; the two low bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Bundle of all fetch-side signals between the sequencer and its neighbours
// (PC register, instruction memory, decode, execute redirect/trap).
//
// Handshakes:
//   imem_req/imem_ack : imem_req rises with imem_addr and both hold steady
//     until the cycle imem_ack is seen high (ack may come in the very first
//     req cycle); imem_rdata is valid only in the ack cycle. One request
//     outstanding at most.
//   instr_valid/instr_ready : a word transfers to decode on any rising edge
//     where both are high; instr/instr_pc stay stable while valid is high and
//     ready is low.
interface pc_fetch_ctrl_if;
  import pc_fetch_ctrl_pkg::*;

  logic [31:0]  pc_in;
  logic         pc_en;
  logic [31:0]  next_pc;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic         instr_valid;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic         instr_ready;
  logic         redirect_valid;
  logic [31:0]  redirect_target;
  logic         trap_valid;
  fetch_state_e state_dbg;

  modport master (
    input  pc_in, imem_ack, imem_rdata, instr_ready,
           redirect_valid, redirect_target, trap_valid,
    output pc_en, next_pc, imem_req, imem_addr,
           instr_valid, instr, instr_pc, state_dbg
  );

  modport slave (
    output pc_in, imem_ack, imem_rdata, instr_ready,
           redirect_valid, redirect_target, trap_valid,
    input  pc_en, next_pc, imem_req, imem_addr,
           instr_valid, instr, instr_pc, state_dbg
  );

endinterface

// File: rtl/pc_fetch_ctrl_fetch_buf.sv
// One-entry instruction buffer toward decode: load wins over consume/flush,
// which both just drop the valid bit and leave the last word in place.
module pc_fetch_ctrl_fetch_buf
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         consume_i,
  input  logic         flush_i,
  input  logic [31:0]  data_i,
  input  logic [31:0]  pc_i,
  output logic         valid_o,
  output logic [31:0]  data_o,
  output logic [31:0]  pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [31:0] pc_q, pc_d;

  // Next buffer contents.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (flush_i || consume_i) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers, async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= RESET_INSTR;
      pc_q    <= 32'h0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC fetch sequencer: drives the PC register load, issues one instruction
// fetch at a time and parks the returned word in a one-entry buffer.
// Trap beats redirect beats sequential advance; either kill discards any
// in-flight or buffered fetch.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC  = TRAP_VEC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  pc_fetch_ctrl_if.master    bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;

  logic         kill;
  logic [31:0]  kill_target;
  logic [31:0]  seq_pc;
  logic         pc_en_c;
  logic [31:0]  next_pc_c;
  logic         enter_fetch;

  logic         buf_load;
  logic         buf_consume;
  logic         buf_flush;
  logic         buf_valid;
  logic [31:0]  buf_data;
  logic [31:0]  buf_pc;

  assign kill        = bus.trap_valid | bus.redirect_valid;
  assign kill_target = bus.trap_valid ? TRAP_VEC : align_word(bus.redirect_target);
  assign seq_pc      = addr_q + 32'd4;  // wraps naturally at 2^32

  // PC register load: kill target, else +4 on an accepted ack; silent in reset.
  always_comb begin
    pc_en_c   = 1'b0;
    next_pc_c = 32'h0;
    if (rst) begin
      if (kill) begin
        pc_en_c   = 1'b1;
        next_pc_c = kill_target;
      end else if (state_q == ST_FETCH && bus.imem_ack) begin
        pc_en_c   = 1'b1;
        next_pc_c = seq_pc;
      end
    end
  end

  // FSM next state, request/address and buffer controls.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_d       = req_q;
    enter_fetch = 1'b0;
    buf_load    = 1'b0;
    // A handshake in the kill cycle still counts as taken by decode.
    buf_consume = buf_valid & bus.instr_ready;
    buf_flush   = kill;

    case (state_q)
      ST_IDLE: begin
        enter_fetch = 1'b1;
      end
      ST_FETCH: begin
        if (bus.imem_ack) begin
          if (kill) begin
            enter_fetch = 1'b1;      // returned word belongs to the old path
          end else begin
            state_d  = ST_HOLD;
            req_d    = 1'b0;
            buf_load = 1'b1;
          end
        end else if (kill) begin
          state_d = ST_FLUSH;        // must still drain the outstanding request
        end
      end
      ST_FLUSH: begin
        if (bus.imem_ack) begin
          enter_fetch = 1'b1;        // stale data dropped
        end
      end
      ST_HOLD: begin
        if (kill || bus.instr_ready) begin
          enter_fetch = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase

    // A new fetch goes to the PC being loaded this cycle, else the current PC.
    if (enter_fetch) begin
      state_d = ST_FETCH;
      req_d   = 1'b1;
      addr_d  = pc_en_c ? next_pc_c : bus.pc_in;
    end
  end

  // State, request and address registers, async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  pc_fetch_ctrl_fetch_buf #(
    .RESET_INSTR (NOP_INSTR)
  ) u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .load_i    (buf_load),
    .consume_i (buf_consume),
    .flush_i   (buf_flush),
    .data_i    (bus.imem_rdata),
    .pc_i      (addr_q),
    .valid_o   (buf_valid),
    .data_o    (buf_data),
    .pc_o      (buf_pc)
  );

  assign bus.pc_en       = pc_en_c;
  assign bus.next_pc     = next_pc_c;
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = buf_valid;
  assign bus.instr       = buf_data;
  assign bus.instr_pc    = buf_pc;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a small PC register model and an
// instruction scoreboard ({pc, word} pushed at accepted acks, popped at the
// decode handshake).
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic [31:0] pc_reg;
  logic [31:0] pc_rst_val;
  logic [63:0] exp_q[$];
  int          total;
  int          bad;
  int          pulses;

  pc_fetch_ctrl_if bus();

  pc_fetch_ctrl #(
    .TRAP_VEC  (32'h00000100),
    .NOP_INSTR (32'h00000013)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // PC register model driven by pc_en/next_pc
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_reg <= pc_rst_val;
    else if (bus.pc_en) pc_reg <= bus.next_pc;
  end
  assign bus.pc_in = pc_reg;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Scoreboard / comparison helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic take(input string tag);
    logic [63:0] e;
    bus.instr_ready = 1'b1;
    #1;
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_pc"}, bus.instr_pc, e[63:32]);
      chk({tag, "_instr"}, bus.instr, e[31:0]);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    pulses = 0;
    pc_rst_val = 32'h0;
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0;
    bus.trap_valid = 1'b1;           // kill held during reset must not load the PC

    // Reset values
    tick(); tick(); settle();
    chk("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, NOP);
    chk("rst_ipc", bus.instr_pc, 32'h0);
    chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
    chk("rst_next_pc", bus.next_pc, 32'h0);
    bus.trap_valid = 1'b0;

    // T1: first fetch with zero-wait ack
    tick(); rst = 1'b1; settle();
    chk("t1_idle", 32'(bus.state_dbg), 32'(ST_IDLE));
    chk("t1_idle_req", 32'(bus.imem_req), 32'd0);
    tick(); bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00500093; settle();
    chk("t1_req", 32'(bus.imem_req), 32'd1);
    chk("t1_addr", bus.imem_addr, 32'h0);
    chk("t1_pc_en", 32'(bus.pc_en), 32'd1);
    chk("t1_next_pc", bus.next_pc, 32'h4);
    exp_q.push_back({32'h0, 32'h00500093});
    tick(); bus.imem_ack = 1'b0; settle();
    chk("t1_hold", 32'(bus.state_dbg), 32'(ST_HOLD));
    chk("t1_req_drop", 32'(bus.imem_req), 32'd0);
    chk("t1_pc_reg", pc_reg, 32'h4);
    chk("t1_instr", bus.instr, 32'h00500093);
    take("t1");

    // T2: ack delayed 3 cycles, then zero-wait at 8
    tick(); bus.instr_ready = 1'b0; settle();
    chk("t2_addr_c0", bus.imem_addr, 32'h4);
    chk("t2_req_c0", 32'(bus.imem_req), 32'd1);
    pulses += int'(bus.pc_en);
    for (int i = 1; i < 3; i++) begin
      tick(); settle();
      chk("t2_addr_wait", bus.imem_addr, 32'h4);
      chk("t2_req_wait", 32'(bus.imem_req), 32'd1);
      pulses += int'(bus.pc_en);
    end
    tick(); bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00a00113; settle();
    chk("t2_addr_c3", bus.imem_addr, 32'h4);
    chk("t2_next_pc", bus.next_pc, 32'h8);
    pulses += int'(bus.pc_en);
    chk("t2_pulses", 32'(pulses), 32'd1);
    exp_q.push_back({32'h4, 32'h00a00113});
    tick(); bus.imem_ack = 1'b0; settle();
    take("t2a");
    tick(); bus.instr_ready = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h002081b3; settle();
    chk("t2_addr8", bus.imem_addr, 32'h8);
    chk("t2_next_pc12", bus.next_pc, 32'hc);
    exp_q.push_back({32'h8, 32'h002081b3});
    tick(); bus.imem_ack = 1'b0; settle();
    take("t2b");
    tick(); bus.instr_ready = 1'b0; settle();
    chk("t2_addr12", bus.imem_addr, 32'hc);

    // T3: redirect while FETCH waits
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h00000202; settle();
    chk("t3_pc_en", 32'(bus.pc_en), 32'd1);
    chk("t3_next_pc", bus.next_pc, 32'h200);
    tick(); bus.redirect_valid = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hdeadbeef; settle();
    chk("t3_flush", 32'(bus.state_dbg), 32'(ST_FLUSH));
    chk("t3_stale_addr", bus.imem_addr, 32'hc);
    chk("t3_flush_pc_en", 32'(bus.pc_en), 32'd0);
    tick(); bus.imem_ack = 1'b0; settle();
    chk("t3_addr200", bus.imem_addr, 32'h200);
    chk("t3_valid0", 32'(bus.instr_valid), 32'd0);
    tick(); bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00100213; settle();
    chk("t3_next_pc204", bus.next_pc, 32'h204);
    exp_q.push_back({32'h200, 32'h00100213});
    tick(); bus.imem_ack = 1'b0; settle();
    take("t3");
    tick(); bus.instr_ready = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h11111111; settle();
    chk("t3_addr204", bus.imem_addr, 32'h204);
    tick(); bus.imem_ack = 1'b0; settle();
    chk("t3_hold_ipc", bus.instr_pc, 32'h204);

    // T4: trap and redirect together in HOLD
    bus.trap_valid = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h444; settle();
    chk("t4_pc_en", 32'(bus.pc_en), 32'd1);
    chk("t4_next_pc", bus.next_pc, 32'h100);
    tick(); bus.trap_valid = 1'b0; bus.redirect_valid = 1'b0; settle();
    chk("t4_valid0", 32'(bus.instr_valid), 32'd0);
    chk("t4_addr", bus.imem_addr, 32'h100);
    chk("t4_req", 32'(bus.imem_req), 32'd1);

    // T5: decode stalls 5 cycles in HOLD
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00300293; settle();
    exp_q.push_back({32'h100, 32'h00300293});
    tick(); bus.imem_ack = 1'b0; settle();
    for (int i = 0; i < 5; i++) begin
      chk("t5_instr", bus.instr, 32'h00300293);
      chk("t5_ipc", bus.instr_pc, 32'h100);
      chk("t5_req", 32'(bus.imem_req), 32'd0);
      chk("t5_pc_en", 32'(bus.pc_en), 32'd0);
      tick(); settle();
    end
    take("t5");
    tick(); bus.instr_ready = 1'b0; settle();
    chk("t5_new_addr", bus.imem_addr, 32'h104);

    // T6: ack and redirect in the same FETCH cycle
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h22222222;
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h301; settle();
    chk("t6_next_pc", bus.next_pc, 32'h300);
    tick(); bus.imem_ack = 1'b0; bus.redirect_valid = 1'b0; settle();
    chk("t6_state", 32'(bus.state_dbg), 32'(ST_FETCH));
    chk("t6_addr", bus.imem_addr, 32'h300);
    chk("t6_valid0", 32'(bus.instr_valid), 32'd0);

    // T7: sequential advance wraps at the top of the address space
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'hffffffff; settle();
    chk("t7_next_pc", bus.next_pc, 32'hfffffffc);
    tick(); bus.redirect_valid = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h33333333; settle();
    chk("t7_flush", 32'(bus.state_dbg), 32'(ST_FLUSH));
    tick(); bus.imem_ack = 1'b0; settle();
    chk("t7_addr_top", bus.imem_addr, 32'hfffffffc);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00400313; settle();
    chk("t7_wrap", bus.next_pc, 32'h0);
    exp_q.push_back({32'hfffffffc, 32'h00400313});
    tick(); bus.imem_ack = 1'b0; settle();
    take("t7");
    tick(); bus.instr_ready = 1'b0; settle();
    chk("t7_addr0", bus.imem_addr, 32'h0);

    // T8: reset asserted mid-FLUSH, stale ack in IDLE
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h80; settle();
    tick(); bus.redirect_valid = 1'b0; settle();
    chk("t8_flush", 32'(bus.state_dbg), 32'(ST_FLUSH));
    pc_rst_val = 32'h40; rst = 1'b0; settle();
    chk("t8_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    chk("t8_req", 32'(bus.imem_req), 32'd0);
    chk("t8_addr", bus.imem_addr, 32'h0);
    chk("t8_valid", 32'(bus.instr_valid), 32'd0);
    chk("t8_instr", bus.instr, NOP);
    chk("t8_ipc", bus.instr_pc, 32'h0);
    chk("t8_pc_en", 32'(bus.pc_en), 32'd0);
    chk("t8_next_pc", bus.next_pc, 32'h0);
    tick(); rst = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hbadbad00; settle();
    chk("t8_idle", 32'(bus.state_dbg), 32'(ST_IDLE));
    chk("t8_idle_pc_en", 32'(bus.pc_en), 32'd0);
    tick(); bus.imem_ack = 1'b0; settle();
    chk("t8_first_addr", bus.imem_addr, 32'h40);
    chk("t8_first_req", 32'(bus.imem_req), 32'd1);
    chk("t8_first_valid", 32'(bus.instr_valid), 32'd0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00700393; settle();
    exp_q.push_back({32'h40, 32'h00700393});
    tick(); bus.imem_ack = 1'b0; settle();
    take("t8");
    tick(); bus.instr_ready = 1'b0; settle();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch sequencer for the PC register. It drives the PC's enable and next-PC inputs, issues one instruction-memory request at a time, and holds the fetched word in a one-entry buffer toward decode. Trap and branch/jump redirects from execute override sequential advance and flush in-flight or buffered fetches. It sits between the PC register, instruction memory and the decode stage.

Parameters:
TRAP_VEC, 32'h00000100, PC loaded on trap_valid.
NOP_INSTR, 32'h00000013, instr value at reset (addi x0,x0,0).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
pc_in  in  32  current PC register value
pc_en  out  1  PC load enable (combinational)
next_pc  out  32  PC load value (combinational)
imem_req  out  1  fetch request, registered
imem_addr  out  32  fetch address, registered (addr_q)
imem_ack  in  1  memory response valid; imem_rdata valid this cycle
imem_rdata  in  32  fetched word
instr_valid  out  1  buffer holds a valid instruction
instr  out  32  buffered instruction
instr_pc  out  32  address of buffered instruction
instr_ready  in  1  decode accepts buffer this cycle
redirect_valid  in  1  taken branch/jump from execute
redirect_target  in  32  redirect address; bits [1:0] forced to 0
trap_valid  in  1  trap request

Behaviour:
- Reset (rst=0, async): state IDLE, imem_req=0, imem_addr=0, instr_valid=0, instr=NOP_INSTR, instr_pc=0. pc_en=0 and next_pc=0 while rst=0.
- kill = trap_valid | redirect_valid. Priority: reset > trap > redirect > sequential advance.
- On kill (any state): pc_en=1; next_pc=TRAP_VEC if trap_valid, else {redirect_target[31:2],2'b00}. instr_valid clears at the next edge. A same-cycle instr_valid&instr_ready handshake still counts as consumed.
- Sequential advance: on an accepted ack (FETCH, imem_ack=1, no kill): pc_en=1 and next_pc=addr_q+4 (mod 2^32; 32'hFFFFFFFC wraps to 0). The buffer captures instr<=imem_rdata, instr_pc<=addr_q, instr_valid<=1.
- In all other cases pc_en=0.
- Memory protocol: imem_req stays high from issue until imem_ack, with imem_addr stable. Ack may arrive in the first req cycle. At most one outstanding request.
- Whenever the FSM enters FETCH, addr_q loads (pc_en ? next_pc : pc_in).
- States:
  - IDLE: one cycle after reset release, then -> FETCH (imem_req=1, addr = pc_in, or the kill target).
  - FETCH, no ack: kill -> FLUSH; else stay.
  - FETCH, ack, kill: data discarded, -> FETCH at the kill target.
  - FETCH, ack, no kill: -> HOLD (buffer full), imem_req drops.
  - FLUSH: imem_req held at the stale address. On ack: data discarded, -> FETCH (addr = pc_in, or a new kill target). A kill with no ack updates the PC and stays in FLUSH.
  - HOLD: kill -> FETCH at target, buffer cleared. instr_ready -> FETCH at pc_in, instr_valid cleared. Otherwise hold; instr/instr_pc stable.
- Throughput: one instruction per 2 cycles with a zero-wait memory. This is accepted for this revision.
- Reset mid-fetch: everything returns to reset values immediately. A stale ack after reset is ignored, because IDLE ignores imem_ack.

Decomposition:
- Shared defines header: state encodings (IDLE/FETCH/FLUSH/HOLD, 2 bits), NOP_INSTR, default TRAP_VEC, instruction width 32.
- One sub-module is natural: fetch_buf (one-entry valid/data/pc register with load, consume and flush). The FSM and next-PC mux stay in the top.

Test Plan:
- Reset release, pc_in=0, zero-wait ack with rdata=32'h00500093 -> imem_req=1 with addr 0 one cycle after IDLE. Then instr_valid=1, instr=32'h00500093, instr_pc=0, and the PC loads 4 at the ack edge.
- Ack delayed 3 cycles, decode ready -> imem_addr stable for all 4 req cycles, exactly one pc_en pulse, fetches at 0,4,8 in order.
- Redirect to 32'h00000202 while FETCH waits -> next_pc=32'h00000200 with pc_en=1 that cycle, FLUSH. The next ack is discarded, then a request at 0x200 returns the first buffered instruction with instr_pc=0x200.
- trap_valid and redirect_valid together in HOLD with instr_ready=0 -> next_pc=32'h00000100, instr_valid=0 next cycle, request at 0x100.
- instr_ready low for 5 cycles in HOLD -> instr/instr_pc unchanged, imem_req=0, pc_en=0 throughout. Ready high -> a new request at pc_in+0.
- Assert rst mid-FLUSH, release, ack a stale response in IDLE -> all outputs at reset values, stale ack ignored, first request at pc_in.
